// File: rtl/kt_pkg.sv
// Shared constants, FSM states and error codes for the knight's-tour checker.
// Imported by the checker, its move-legality helper and the bench.
package kt_pkg;

    localparam int BOARD_DIM = 5;
    localparam int CELLS     = 25;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT,
        STREAM,
        REPORT
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_FRAME   = 3'd2;
    localparam logic [2:0] ERR_BOUNDS  = 3'd3;
    localparam logic [2:0] ERR_KNIGHT  = 3'd4;
    localparam logic [2:0] ERR_REVISIT = 3'd5;
    localparam logic [2:0] ERR_PREFIX  = 3'd6;
    localparam logic [2:0] ERR_PROTO   = 3'd7;

endpackage

// File: rtl/kt_move_legal.sv
// Combinational move classifier: board bounds, knight-move shape and the
// flat cell index (5x+y) of the current cell.
module kt_move_legal
    import kt_pkg::*;
(
    input  logic [2:0] prev_x,
    input  logic [2:0] prev_y,
    input  logic [2:0] curr_x,
    input  logic [2:0] curr_y,
    output logic       in_bounds,
    output logic       is_knight,
    output logic [4:0] cell_idx
);

    logic [3:0] dx;
    logic [3:0] dy;
    logic [3:0] adx;
    logic [3:0] ady;

    // 4-bit two's-complement differences of zero-extended coordinates; the
    // magnitude is all that matters for the knight test.
    always_comb begin
        dx        = {1'b0, curr_x} - {1'b0, prev_x};
        dy        = {1'b0, curr_y} - {1'b0, prev_y};
        adx       = dx[3] ? (4'd0 - dx) : dx;
        ady       = dy[3] ? (4'd0 - dy) : dy;
        in_bounds = (curr_x < 3'(BOARD_DIM)) && (curr_y < 3'(BOARD_DIM));
        is_knight = ((adx == 4'd1) && (ady == 4'd2)) ||
                    ((adx == 4'd2) && (ady == 4'd1));
        cell_idx  = in_bounds ? (({2'b00, curr_x} << 2) + {2'b00, curr_x} + {2'b00, curr_y})
                              : 5'd0;
    end

endmodule

// File: rtl/kt_checker.sv
// Passive scoreboard for the knight's-tour block: records the input prefix,
// checks the 25-beat output tour and reports the first error and its step.
module kt_checker
    import kt_pkg::*;
#(
    parameter int TIMEOUT = 3000,
    parameter int TO_W    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_x,
    input  logic [2:0] in_y,
    input  logic [4:0] move_num,
    input  logic       out_valid,
    input  logic [2:0] out_x,
    input  logic [2:0] out_y,
    input  logic [4:0] move_out,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_code,
    output logic [4:0] err_step
);

    state_t state;
    state_t next_state;

    logic [4:0]       move_num_r;
    logic [4:0]       ibeat;
    logic [4:0]       obeat;
    logic [4:0]       beat_k;
    logic [2:0]       prefix_x [CELLS];
    logic [2:0]       prefix_y [CELLS];
    logic [CELLS-1:0] visited;
    logic [2:0]       prev_x;
    logic [2:0]       prev_y;
    logic [TO_W-1:0]  to_cnt;

    logic       in_bounds;
    logic       is_knight;
    logic [4:0] cell_idx;

    logic       err_hit;
    logic [2:0] err_c;
    logic [4:0] err_s;
    logic       beat_take;
    logic       to_hit;
    logic       new_run;
    logic [2:0] err_code_base;
    logic [4:0] err_step_base;
    logic [2:0] err_code_nxt;
    logic [4:0] err_step_nxt;

    kt_move_legal u_move (
        .prev_x    (prev_x),
        .prev_y    (prev_y),
        .curr_x    (out_x),
        .curr_y    (out_y),
        .in_bounds (in_bounds),
        .is_knight (is_knight),
        .cell_idx  (cell_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, this cycle's candidate error and the first-error merge.
    // A new run clears the latched error before anything new is merged in.
    always_comb begin
        next_state = state;
        err_hit    = 1'b0;
        err_c      = ERR_NONE;
        err_s      = 5'd0;
        beat_take  = 1'b0;
        done       = 1'b0;
        beat_k     = obeat + 5'd1;
        to_hit     = (to_cnt == TO_W'(TIMEOUT - 1));
        new_run    = (state == IDLE) && in_valid;

        case (state)
            IDLE: begin
                if (out_valid) begin
                    err_hit = 1'b1;
                    err_c   = ERR_PROTO;
                end
                if (in_valid) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    if (out_valid || (ibeat >= 5'(CELLS))) begin
                        err_hit = 1'b1;
                        err_c   = ERR_PROTO;
                    end
                end else begin
                    next_state = WAIT;
                    if ((ibeat != move_num_r) || (move_num_r == 5'd0) ||
                        (move_num_r > 5'(CELLS))) begin
                        err_hit = 1'b1;
                        err_c   = ERR_PROTO;
                    end
                end
            end
            WAIT: begin
                if (to_hit) begin
                    err_hit    = 1'b1;
                    err_c      = ERR_TIMEOUT;
                    err_s      = obeat;
                    next_state = REPORT;
                end else if (out_valid) begin
                    beat_take  = 1'b1;
                    next_state = STREAM;
                end else if ((out_x != 3'd0) || (out_y != 3'd0) || (move_out != 5'd0)) begin
                    err_hit = 1'b1;
                    err_c   = ERR_PROTO;
                end
            end
            STREAM: begin
                if (to_hit) begin
                    err_hit    = 1'b1;
                    err_c      = ERR_TIMEOUT;
                    err_s      = obeat;
                    next_state = REPORT;
                end else if (out_valid) begin
                    if (obeat == 5'(CELLS)) begin
                        err_hit = 1'b1;
                        err_c   = ERR_FRAME;
                        err_s   = 5'(CELLS);
                    end else begin
                        beat_take = 1'b1;
                    end
                end else begin
                    if (obeat != 5'(CELLS)) begin
                        err_hit = 1'b1;
                        err_c   = ERR_FRAME;
                        err_s   = beat_k;
                    end
                    next_state = REPORT;
                end
            end
            REPORT: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Per-beat rule checks, lowest code wins when several fail together.
        if (beat_take) begin
            err_hit = 1'b1;
            err_s   = beat_k;
            if (move_out != beat_k) begin
                err_c = ERR_FRAME;
            end else if (!in_bounds) begin
                err_c = ERR_BOUNDS;
            end else if ((obeat != 5'd0) && !is_knight) begin
                err_c = ERR_KNIGHT;
            end else if (visited[cell_idx]) begin
                err_c = ERR_REVISIT;
            end else if ((beat_k <= move_num_r) &&
                         ((out_x != prefix_x[obeat]) || (out_y != prefix_y[obeat]))) begin
                err_c = ERR_PREFIX;
            end else begin
                err_hit = 1'b0;
                err_s   = 5'd0;
            end
        end

        err_code_base = new_run ? ERR_NONE : err_code;
        err_step_base = new_run ? 5'd0 : err_step;
        if (err_hit && (err_code_base == ERR_NONE)) begin
            err_code_nxt = err_c;
            err_step_nxt = err_s;
        end else begin
            err_code_nxt = err_code_base;
            err_step_nxt = err_step_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_num_r <= 5'd0;
            ibeat      <= 5'd0;
            obeat      <= 5'd0;
            visited    <= '0;
            prev_x     <= 3'd0;
            prev_y     <= 3'd0;
            to_cnt     <= '0;
            pass       <= 1'b0;
            err_code   <= ERR_NONE;
            err_step   <= 5'd0;
            for (int i = 0; i < CELLS; i++) begin
                prefix_x[i] <= 3'd0;
                prefix_y[i] <= 3'd0;
            end
        end else begin
            err_code <= err_code_nxt;
            err_step <= err_step_nxt;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pass        <= 1'b0;
                        visited     <= '0;
                        obeat       <= 5'd0;
                        to_cnt      <= '0;
                        move_num_r  <= move_num;
                        prefix_x[0] <= in_x;
                        prefix_y[0] <= in_y;
                        ibeat       <= 5'd1;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        if (ibeat < 5'(CELLS)) begin
                            prefix_x[ibeat] <= in_x;
                            prefix_y[ibeat] <= in_y;
                            ibeat           <= ibeat + 5'd1;
                        end
                    end else begin
                        to_cnt <= '0;
                    end
                end
                WAIT, STREAM: begin
                    to_cnt <= to_cnt + 1'b1;
                end
                default: begin
                end
            endcase

            // Out-of-bounds cells still become "previous" but never mark the map.
            if (beat_take) begin
                if (in_bounds) begin
                    visited[cell_idx] <= 1'b1;
                end
                prev_x <= out_x;
                prev_y <= out_y;
                obeat  <= beat_k;
            end

            if ((next_state == REPORT) && (state != REPORT)) begin
                pass <= (err_code_nxt == ERR_NONE);
            end
        end
    end

endmodule
